cyclotron_difftest_serializer: RTL and testbench

- Synthesizable front stage for the Cyclotron register difftest.
- Accepts one retired-instruction trace per cycle carrying up to NUM_PORTS register writebacks, plus a lane mask.
- Buffers traces in an instruction FIFO and serializes them into a one-writeback-per-beat commit stream with valid/ready backpressure.
- Sits between core writeback and the DPI checker, so the checker sees an ordered, sequence-numbered stream with no dropped retirements.

---
 rtl/cyclotron_difftest_serializer.sv | 109 ++++++++++
 tb/tb_cyclotron_difftest_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyclotron_difftest_serializer.sv
// cyclotron_difftest_serializer: buffers retired-instruction traces in a FIFO and
// serializes each one into a stream of one-writeback-per-beat commit beats.
module cyclotron_difftest_serializer #(
    parameter int ARCH_LEN   = 32,
    parameter int NUM_LANES  = 16,
    parameter int NUM_WARPS  = 8,
    parameter int REG_BITS   = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_BITS   = 16,
    localparam int WARP_ID_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1,
    localparam int PORT_BITS    = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
    localparam int OCC_BITS     = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_BITS     = $clog2(FIFO_DEPTH),
    localparam int DATA_W       = NUM_LANES * ARCH_LEN
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           trace_valid,
    output logic                           trace_ready,
    input  logic [ARCH_LEN-1:0]            trace_pc,
    input  logic [WARP_ID_BITS-1:0]        trace_warpId,
    input  logic [NUM_LANES-1:0]           trace_tmask,
    input  logic [NUM_PORTS-1:0]           trace_regs_enable,
    input  logic [NUM_PORTS*REG_BITS-1:0]  trace_regs_address,
    input  logic [NUM_PORTS*DATA_W-1:0]    trace_regs_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARCH_LEN-1:0]            out_pc,
    output logic [WARP_ID_BITS-1:0]        out_warpId,
    output logic [NUM_LANES-1:0]           out_tmask,
    output logic                           out_has_reg,
    output logic [PORT_BITS-1:0]           out_port,
    output logic [REG_BITS-1:0]            out_address,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic [SEQ_BITS-1:0]            out_seq,
    output logic [OCC_BITS-1:0]            occupancy
);
    logic [ARCH_LEN-1:0]           pc_q    [FIFO_DEPTH];
    logic [WARP_ID_BITS-1:0]       warp_q  [FIFO_DEPTH];
    logic [NUM_LANES-1:0]          tmask_q [FIFO_DEPTH];
    logic [NUM_PORTS-1:0]          en_q    [FIFO_DEPTH];
    logic [NUM_PORTS*REG_BITS-1:0] addr_q  [FIFO_DEPTH];
    logic [NUM_PORTS*DATA_W-1:0]   data_q  [FIFO_DEPTH];
    logic [SEQ_BITS-1:0]           eseq_q  [FIFO_DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_BITS-1:0] occ_q, occ_d;
    logic [NUM_PORTS-1:0] done_q, done_d, pending;
    logic [SEQ_BITS-1:0] seq_q, seq_d;
    logic [PORT_BITS-1:0] sel;
    logic head_valid, enq, fire, pop;

    // done_q tracks ports already emitted for the head, so pending is the head's enables minus done
    always_comb begin
        head_valid = occ_q != '0;
        pending = en_q[rd_ptr_q] & ~done_q;
        sel = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) sel = pending[p] ? PORT_BITS'(p) : sel;
        trace_ready = reset && (occ_q < OCC_BITS'(FIFO_DEPTH));
        enq = trace_valid && trace_ready;
        out_valid = head_valid;
        out_has_reg = head_valid && (|pending);
        out_last = head_valid && ((pending & (pending - NUM_PORTS'(1))) == '0);
        out_port = head_valid ? sel : '0;
        out_pc = head_valid ? pc_q[rd_ptr_q] : '0;
        out_warpId = head_valid ? warp_q[rd_ptr_q] : '0;
        out_tmask = head_valid ? tmask_q[rd_ptr_q] : '0;
        out_seq = head_valid ? eseq_q[rd_ptr_q] : '0;
        out_address = out_has_reg ? addr_q[rd_ptr_q][REG_BITS*sel +: REG_BITS] : '0;
        out_data = out_has_reg ? data_q[rd_ptr_q][DATA_W*sel +: DATA_W] : '0;
        occupancy = occ_q;
        fire = out_valid && out_ready;
        pop = fire && out_last;
        done_d = pop ? '0 : fire ? (done_q | (NUM_PORTS'(1) << sel)) : done_q;
        rd_ptr_d = rd_ptr_q + PTR_BITS'(pop);
        wr_ptr_d = wr_ptr_q + PTR_BITS'(enq);
        occ_d = occ_q + OCC_BITS'(enq) - OCC_BITS'(pop);
        seq_d = seq_q + SEQ_BITS'(enq);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q <= '0;
            done_q <= '0;
            seq_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q <= occ_d;
            done_q <= done_d;
            seq_q <= seq_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            pc_q[wr_ptr_q] <= trace_pc;
            warp_q[wr_ptr_q] <= trace_warpId;
            tmask_q[wr_ptr_q] <= trace_tmask;
            en_q[wr_ptr_q] <= trace_regs_enable;
            addr_q[wr_ptr_q] <= trace_regs_address;
            data_q[wr_ptr_q] <= trace_regs_data;
            eseq_q[wr_ptr_q] <= seq_q;
        end
    end
endmodule

// File: tb/tb_cyclotron_difftest_serializer.sv
// tb_cyclotron_difftest_serializer: random and directed traces scored against a queue of
// expected commit beats built from each accepted trace.
module tb_cyclotron_difftest_serializer;
    localparam int AL = 32, NL = 16, NP = 3, RB = 8, FD = 8, SB = 4, DW = NL * AL;

    logic clock, reset, trace_valid, trace_ready, out_valid, out_ready;
    logic [AL-1:0] trace_pc, out_pc;
    logic [2:0] trace_warpId, out_warpId;
    logic [NL-1:0] trace_tmask, out_tmask;
    logic [NP-1:0] trace_regs_enable;
    logic [NP*RB-1:0] trace_regs_address;
    logic [NP*DW-1:0] trace_regs_data;
    logic out_has_reg, out_last;
    logic [1:0] out_port;
    logic [RB-1:0] out_address;
    logic [DW-1:0] out_data;
    logic [SB-1:0] out_seq;
    logic [3:0] occupancy;

    typedef struct packed {
        logic [AL-1:0] pc;
        logic [2:0] warp;
        logic [NL-1:0] tmask;
        logic has_reg;
        logic [1:0] port;
        logic [RB-1:0] addr;
        logic [DW-1:0] data;
        logic last;
        logic [SB-1:0] seq;
    } beat_t;

    beat_t exp_q[$];
    int total = 0, bad = 0, model_seq = 0;
    bit busy;

    cyclotron_difftest_serializer #(.SEQ_BITS(SB)) dut (
        .clock(clock), .reset(reset), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_warpId(trace_warpId), .trace_tmask(trace_tmask),
        .trace_regs_enable(trace_regs_enable), .trace_regs_address(trace_regs_address),
        .trace_regs_data(trace_regs_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_warpId(out_warpId), .out_tmask(out_tmask),
        .out_has_reg(out_has_reg), .out_port(out_port), .out_address(out_address),
        .out_data(out_data), .out_last(out_last), .out_seq(out_seq), .occupancy(occupancy)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(string name, longint got, longint req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic cmp_beat(string name, beat_t e);
        beat_t g;
        g = '{out_pc, out_warpId, out_tmask, out_has_reg, out_port, out_address, out_data, out_last, out_seq};
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got pc=%h w=%0d has=%0d port=%0d addr=%0d last=%0d seq=%0d data_ok=%0d required pc=%h w=%0d has=%0d port=%0d addr=%0d last=%0d seq=%0d",
                     name, g.pc, g.warp, g.has_reg, g.port, g.addr, g.last, g.seq, g.data == e.data,
                     e.pc, e.warp, e.has_reg, e.port, e.addr, e.last, e.seq);
        end
    endtask

    // Expected beats: one per enabled port in ascending order, or a single empty beat
    task automatic push_model();
        beat_t b;
        b = '0;
        b.pc = trace_pc;
        b.warp = trace_warpId;
        b.tmask = trace_tmask;
        b.seq = SB'(model_seq % (1 << SB));
        if (trace_regs_enable == 0) begin
            b.last = 1;
            exp_q.push_back(b);
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (trace_regs_enable[p]) begin
                    b.has_reg = 1;
                    b.port = 2'(p);
                    b.addr = trace_regs_address[p*RB +: RB];
                    b.data = trace_regs_data[p*DW +: DW];
                    b.last = (trace_regs_enable >> (p + 1)) == 0;
                    exp_q.push_back(b);
                end
            end
        end
        model_seq++;
    endtask

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got seq=%0d port=%0d required no beat", out_seq, out_port);
            end else cmp_beat("beat", exp_q.pop_front());
        end
    end

    task automatic rand_fill(logic [NP-1:0] en);
        trace_pc = $urandom;
        trace_warpId = 3'($urandom_range(0, 7));
        trace_tmask = NL'($urandom);
        trace_regs_enable = en;
        trace_regs_address = (NP*RB)'($urandom);
        for (int i = 0; i < NP * DW / 32; i++) trace_regs_data[i*32 +: 32] = $urandom;
    endtask

    task automatic send();
        bit ok = 0;
        trace_valid = 1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (trace_ready) begin
                push_model();
                ok = 1;
            end
            @(posedge clock);
            #1;
        end
        trace_valid = 0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept required accept within 300 cycles");
        end
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && occupancy == 0) break;
            @(negedge clock);
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_occ"}, occupancy, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1;
        trace_valid = 0;
        out_ready = 1;
        rand_fill(3'b000);
        #2 reset = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", trace_ready, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_seq", out_seq, 0);
        reset = 1;
        #1 chk("rel_ready", trace_ready, 1);
        @(posedge clock);
        #1;

        rand_fill(3'b101);
        trace_pc = 32'h8000_0000;
        trace_warpId = 3;
        trace_regs_address = {8'd9, 8'd0, 8'd5};
        trace_valid = 1;
        @(negedge clock);
        chk("no_forward", out_valid, 0);
        chk("single_ready", trace_ready, 1);
        push_model();
        @(posedge clock);
        #1;
        trace_valid = 0;
        chk("lat1_valid", out_valid, 1);
        chk("lat1_occ", occupancy, 1);
        chk("lat1_port", out_port, 0);
        chk("lat1_addr", out_address, 5);
        chk("lat1_last", out_last, 0);
        drain("single");

        rand_fill(3'b000);
        trace_pc = 32'h100;
        send();
        chk("zero_has", out_has_reg, 0);
        chk("zero_last", out_last, 1);
        chk("zero_addr", out_address, 0);
        drain("zero");

        out_ready = 0;
        for (int i = 0; i < FD; i++) begin
            rand_fill(3'($urandom));
            send();
        end
        chk("full_ready", trace_ready, 0);
        chk("full_occ", occupancy, FD);
        rand_fill(3'b111);
        trace_valid = 1;
        repeat (3) begin
            @(negedge clock);
            chk("held_ready", trace_ready, 0);
            chk("held_occ", occupancy, FD);
        end
        @(posedge clock);
        #1;
        out_ready = 1;
        send();
        drain("bp");

        out_ready = 0;
        rand_fill(3'b111);
        send();
        out_ready = 1;
        @(posedge clock);
        #1;
        out_ready = 0;
        repeat (5) begin
            @(negedge clock);
            cmp_beat("stall", exp_q[0]);
        end
        chk("stall_port", out_port, 1);
        @(posedge clock);
        #1;
        out_ready = 1;
        drain("stall");

        busy = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rand_fill(3'($urandom));
                    send();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                end
                busy = 0;
            end
            begin
                while (busy) begin
                    @(posedge clock);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready = 1;
        drain("rand");

        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rand_fill(3'($urandom));
            send();
        end
        chk("pre_rst_occ", occupancy, 3);
        #2 reset = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", trace_ready, 0);
        chk("arst_occ", occupancy, 0);
        exp_q.delete();
        model_seq = 0;
        @(posedge clock);
        #1;
        reset = 1;
        out_ready = 1;
        @(posedge clock);
        #1;
        rand_fill(3'($urandom));
        send();
        chk("post_rst_seq", out_seq, 0);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
